// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide sequencer: funct codes,
// FSM states and funct classification helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // Anything that touches HI/LO or needs the unit must wait while it is busy.
    function automatic logic is_mdu_funct(input logic [5:0] f);
        return is_muldiv(f) || (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Pipeline-to-MDU signal bundle: ID/EX request, IF/ID lookahead, HI/LO and status back.
interface mdu_sequencer_if #(parameter int WIDTH = 32);

    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             ifid_rtype;
    logic [5:0]       ifid_funct;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_out;
    logic             div_zero;

    modport master (
        output start, funct, rs_val, rt_val, ifid_rtype, ifid_funct,
        input  hi, lo, busy, stall_out, div_zero
    );

    modport slave (
        input  start, funct, rs_val, rt_val, ifid_rtype, ifid_funct,
        output hi, lo, busy, stall_out, div_zero
    );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration of the shift-add multiplier / restoring divider
// over a shared 2*WIDTH accumulator ({partial, multiplier} or {remainder, quotient}).
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_mul_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_rem_diff;

    always_comb begin
        w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        if (i_acc[0]) begin
            w_mul_sum = w_mul_sum + {1'b0, i_opnd};
        end
        w_rem_sh   = i_acc[2*WIDTH-1:WIDTH-1];
        w_rem_diff = w_rem_sh - {1'b0, i_opnd};
        // The top bit of the difference is the borrow: set means the divisor did not fit.
        if (i_is_div) begin
            if (!w_rem_diff[WIDTH]) begin
                o_acc = {w_rem_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_mul_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with single-cycle
// MTHI/MTLO and a stall into the pipeline interlock while an operation runs.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic          clock,
    input logic          reset,
    mdu_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_div_zero;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;

    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    // funct[1] selects divide, funct[0] selects the unsigned variant.
    always_comb begin
        w_is_div = bus.funct[1];
        w_signed = !bus.funct[0];
        w_mag_a  = (w_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
        w_mag_b  = (w_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    end

    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.funct == F_MTHI) begin
                            r_hi <= bus.rs_val;
                        end else if (bus.funct == F_MTLO) begin
                            r_lo <= bus.rs_val;
                        end else if (is_muldiv(bus.funct)) begin
                            if (w_is_div && (bus.rt_val == '0)) begin
                                r_div_zero <= 1'b1;
                            end else begin
                                r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                                r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
                                r_is_div  <= w_is_div;
                                r_neg_res <= w_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                                r_neg_rem <= w_signed && bus.rs_val[WIDTH-1];
                                r_cnt     <= '0;
                                r_busy    <= 1'b1;
                                r_state   <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = r_busy;
    assign bus.div_zero  = r_div_zero;
    assign bus.stall_out = r_busy && bus.ifid_rtype && is_mdu_funct(bus.ifid_funct);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: HI/LO moves, signed/unsigned multiply and
// divide, divide-by-zero, interlock stall and asynchronous reset mid-operation.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   n_busy;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.start  = 1'b0;
        bus.funct  = 6'h00;
    endtask

    // Issues an iterative op and counts the cycles busy is seen high (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_stall, output int n);
        issue(f, a, b);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            check1("stall_run", bus.stall_out, exp_stall);
            tick();
        end
        check1("stall_after", bus.stall_out, 1'b0);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.funct      = 6'h00;
        bus.rs_val     = '0;
        bus.rt_val     = '0;
        bus.ifid_rtype = 1'b0;
        bus.ifid_funct = 6'h00;
        #12;
        check32("rst_hi", bus.hi, 32'h0);
        check32("rst_lo", bus.lo, 32'h0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_dz", bus.div_zero, 1'b0);
        check1("rst_stall", bus.stall_out, 1'b0);
        reset = 1'b0;
        tick();

        // MTHI then MTLO back to back, with an MFHI sitting in IF/ID
        bus.ifid_rtype = 1'b1;
        bus.ifid_funct = F_MFHI;
        issue(F_MTHI, 32'h0000ABCD, 32'h0);
        check32("mthi_hi", bus.hi, 32'h0000ABCD);
        check32("mthi_lo", bus.lo, 32'h0);
        check1("mthi_busy", bus.busy, 1'b0);
        check1("mthi_stall", bus.stall_out, 1'b0);
        issue(F_MTLO, 32'h00001234, 32'h0);
        check32("mtlo_hi", bus.hi, 32'h0000ABCD);
        check32("mtlo_lo", bus.lo, 32'h00001234);
        check1("mtlo_busy", bus.busy, 1'b0);
        check1("mtlo_stall", bus.stall_out, 1'b0);
        bus.ifid_rtype = 1'b0;

        // Signed multiply: -3 * 5 = -15
        run_op(F_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, n_busy);
        check32("mult_cycles", n_busy, 32'd33);
        check32("mult_hi", bus.hi, 32'hFFFFFFFF);
        check32("mult_lo", bus.lo, 32'hFFFFFFF1);

        // Signed divide: -7 / 2 = -3 rem -1
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n_busy);
        check32("div_cycles", n_busy, 32'd33);
        check32("div_lo", bus.lo, 32'hFFFFFFFD);
        check32("div_hi", bus.hi, 32'hFFFFFFFF);

        // Unsigned divide: 0xFFFFFFFF / 16
        run_op(F_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0, n_busy);
        check32("divu_lo", bus.lo, 32'h0FFFFFFF);
        check32("divu_hi", bus.hi, 32'h0000000F);

        // Most negative dividend by -1 wraps to itself
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n_busy);
        check32("divmin_lo", bus.lo, 32'h80000000);
        check32("divmin_hi", bus.hi, 32'h0);

        // Divide by zero leaves HI/LO alone and pulses div_zero once
        issue(F_MTHI, 32'h11, 32'h0);
        issue(F_MTLO, 32'h22, 32'h0);
        issue(F_DIV, 32'd9, 32'd0);
        check1("dz_pulse", bus.div_zero, 1'b1);
        check1("dz_busy", bus.busy, 1'b0);
        tick();
        check1("dz_pulse_end", bus.div_zero, 1'b0);
        check1("dz_busy2", bus.busy, 1'b0);
        check32("dz_hi", bus.hi, 32'h11);
        check32("dz_lo", bus.lo, 32'h22);

        // MFLO waiting in IF/ID stalls for every busy cycle
        bus.ifid_rtype = 1'b1;
        bus.ifid_funct = F_MFLO;
        run_op(F_MULT, 32'd100, 32'd3, 1'b1, n_busy);
        check32("stall_cycles", n_busy, 32'd33);
        check32("stall_lo", bus.lo, 32'd300);
        check32("stall_hi", bus.hi, 32'h0);

        // An independent ADD keeps flowing
        bus.ifid_funct = 6'h20;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, n_busy);
        check32("multu_hi", bus.hi, 32'h00000001);
        check32("multu_lo", bus.lo, 32'hFFFFFFFE);
        bus.ifid_rtype = 1'b0;

        // Asynchronous reset around iteration 10 of a MULT
        issue(F_MULT, 32'd7, 32'd6);
        repeat (10) tick();
        check1("mid_busy", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check1("arst_busy", bus.busy, 1'b0);
        check32("arst_hi", bus.hi, 32'h0);
        check32("arst_lo", bus.lo, 32'h0);
        #1 reset = 1'b0;
        run_op(F_MULTU, 32'd3, 32'd4, 1'b0, n_busy);
        check32("post_cycles", n_busy, 32'd33);
        check32("post_lo", bus.lo, 32'd12);
        check32("post_hi", bus.hi, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline; owns HI/LO.
- Sequences an iterative shift-add multiplier / restoring divider for MULT, MULTU, DIV and DIVU.
- Performs single-cycle MTHI/MTLO writes.
- Drives a stall into the pipeline interlock whenever an instruction in IF/ID needs HI/LO or the unit while an operation is in flight.

Parameters:
- WIDTH, 32: operand width. HI and LO are WIDTH each. Iteration count = WIDTH.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  ID/EX holds a valid R-type MDU instruction this cycle.
- funct  in  6  ID/EX funct field.
- rs_val  in  WIDTH  forwarded rs operand (dividend / multiplicand / MTHI/MTLO source).
- rt_val  in  WIDTH  forwarded rt operand (divisor / multiplier).
- ifid_rtype  in  1  IF/ID instruction has opcode 0.
- ifid_funct  in  6  IF/ID funct field.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  iterative operation in flight.
- stall_out  out  1  freeze PC and IF/ID; bubble into ID/EX.
- div_zero  out  1  one-cycle pulse when DIV/DIVU sees rt_val==0.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; hi=0, lo=0; busy=0; div_zero=0; iteration counter=0.
  - An in-flight operation is abandoned; no partial result is written.
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - Any other funct with start=1 is ignored.
- States: IDLE, RUN, FIXUP.
- IDLE, start=1 with MTHI/MTLO: hi (resp. lo) <= rs_val at the edge. No busy, no stall.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU, at edge E0:
  - Latch operand magnitudes. Signed ops use |x|, taken unsigned, so 0x80000000 stays 0x80000000.
  - Latch sign flags and op kind.
  - Counter <= 0; state <= RUN; busy=1 from E0.
- DIV/DIVU with rt_val==0 at E0:
  - div_zero=1 for exactly the cycle after E0.
  - state stays IDLE; hi/lo unchanged; busy never asserts.
- RUN: one iteration per clock; counter increments.
  - Multiply: 2*WIDTH-bit shift-add accumulator.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
  - After WIDTH iterations (edge E_WIDTH), state <= FIXUP.
- FIXUP, at edge E_WIDTH+1: sign correction, write HI/LO, state <= IDLE, busy <= 0.
  - MULT: 2*WIDTH product negated if operand signs differ; hi=upper half, lo=lower half.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign; lo=quotient, hi=remainder.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Unsigned ops: no correction.
- Timing: busy is high for exactly WIDTH+1 cycles (33 at default). New HI/LO are visible the cycle after busy falls.
- start while busy (RUN/FIXUP): ignored, no state change. The stall guarantees this cannot happen legally.
- stall_out (combinational) = busy AND ifid_rtype AND ifid_funct in {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}.
  - Independent ALU instructions keep flowing during RUN.
- Same-edge events:
  - Reset dominates everything.
  - MTHI/MTLO arriving in the same cycle FIXUP writes cannot occur, because stall_out covers it.
- hi/lo hold their value in every cycle without a write.

Decomposition:
- Package mdu_pkg: funct localparams (MFHI…DIVU), state enum {IDLE, RUN, FIXUP}, WIDTH default.
- Sub-module mdu_step: combinational single iteration.
  - Inputs: op kind, accumulator/remainder, operand.
  - Output: next accumulator/remainder.
  - Instantiated once; the sequencer owns all registers, counter and sign fixup.

Test Plan:
- Reset mid-RUN: MULT 7×6, assert reset at iteration 10 -> busy=0, hi=lo=0 immediately; a following MULTU 3×4 gives lo=12, hi=0 after 33 busy cycles.
- MULT signed: rs=0xFFFFFFFD (−3), rt=5 -> busy exactly 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV signed: rs=−7, rt=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- Divide-by-zero: prior hi=0x11, lo=0x22; DIV rs=9, rt=0 -> div_zero one-cycle pulse, busy stays 0, hi/lo unchanged.
- Stall: MULT started, then ifid MFLO during RUN -> stall_out=1 for every busy cycle and 0 the cycle busy falls; an ifid ADD (funct 0x20) during RUN -> stall_out=0.
- MTHI/MTLO in IDLE: MTHI rs=0xABCD then MTLO rs=0x1234 on consecutive cycles -> hi=0xABCD, lo=0x1234 one edge each; busy and stall_out stay 0.
